// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder/subtractor, LSB first, one bit per clock.
// A WIDTH-bit operation takes WIDTH processing edges under a
// start/busy/done handshake. Defining SERIAL_ADDER_OVF_EN adds the ovf
// port and its register (signed overflow of the final result).
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; outputs hold the last result
// RUN   | one sum bit per edge, LSB first, carry kept in a flop
// DONE  | done pulse cycle; the result is visible on sum/cout(/ovf)

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             cout,
    output logic             ovf
`else
    output logic             cout
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] shreg;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             bit_s;
    logic             carry_nxt;
    logic             last_bit;
    logic             accept;

    // Full-adder slice on the current LSBs; the edge ending the done cycle
    // may also accept a new start so operations can run back to back.
    always_comb begin
        bit_s     = op_a[0] ^ op_b[0] ^ carry;
        carry_nxt = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
        last_bit  = (cnt == LAST_BIT);
        accept    = start && ((state == IDLE) || (state == DONE));
    end

    // Control FSM with registered busy/done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (accept) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (last_bit) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Operand capture and serial shifting. Subtraction is folded into the
    // captured operand and carry (a + ~b + ~cin), so no mode flop is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            shreg <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub ? ~cin : cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            op_a  <= op_a >> 1;
            op_b  <= op_b >> 1;
            carry <= carry_nxt;
            shreg <= {bit_s, shreg[WIDTH-1:1]};
            cnt   <= cnt + CNT_W'(1);
        end
    end

    // Result registers load only on the final bit, so partial shifts never show.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if ((state == RUN) && last_bit) begin
            sum  <= {bit_s, shreg[WIDTH-1:1]};
            cout <= carry_nxt;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if ((state == RUN) && last_bit) begin
            ovf <= carry ^ carry_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: checks an 8-bit and a 2-bit serial_adder against an
// arithmetic reference model with a timing model of the handshake.

module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start2 = 1'b0, sub2 = 1'b0, cin2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0;
    logic       busy2, done2, cout2;
    logic [1:0] sum2;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf8, ovf2;
`endif

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en = 1'b0;
    bit run2 = 1'b0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .cin(cin8), .busy(busy8), .done(done8), .sum(sum8),
`ifdef SERIAL_ADDER_OVF_EN
        .cout(cout8), .ovf(ovf8)
`else
        .cout(cout8)
`endif
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub2), .a(a2), .b(b2),
        .cin(cin2), .busy(busy2), .done(done2), .sum(sum2),
`ifdef SERIAL_ADDER_OVF_EN
        .cout(cout2), .ovf(ovf2)
`else
        .cout(cout2)
`endif
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the add/subtract definitions.
    function automatic void ref_op(input int w, input longint ua, input longint ub,
                                   input bit c, input bit s, output longint rs,
                                   output bit rc, output bit ro);
        longint m, half, t, sa, sb, sv;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        sa   = (ua >= half) ? ua - (half << 1) : ua;
        sb   = (ub >= half) ? ub - (half << 1) : ub;
        if (!s) begin
            t  = ua + ub + longint'(c);
            rc = ((t >> w) & 1) != 0;
            sv = sa + sb + longint'(c);
        end else begin
            t  = ua - ub - longint'(c);
            rc = (ua >= ub + longint'(c));
            sv = sa - sb - longint'(c);
        end
        rs = t & m;
        ro = (sv > half - 1) || (sv < -half);
    endfunction

    // Behavioural model: an operation accepted at edge n ends at edge n+W;
    // busy is high in between, done in the cycle after edge n+W.
    bit     m_act[2]  = '{0, 0};
    longint m_end[2]  = '{0, 0};
    longint p_sum[2]  = '{0, 0};
    bit     p_cout[2] = '{0, 0};
    bit     p_ovf[2]  = '{0, 0};
    longint e_sum[2]  = '{0, 0};
    bit     e_cout[2] = '{0, 0};
    bit     e_ovf[2]  = '{0, 0};
    bit     e_busy[2] = '{0, 0};
    bit     e_done[2] = '{0, 0};
    longint cyc = 0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < 2; i++) begin
                    m_act[i] = 0; e_sum[i] = 0; e_cout[i] = 0; e_ovf[i] = 0;
                    e_busy[i] = 0; e_done[i] = 0;
                end
            end else begin
                cyc++;
                for (int i = 0; i < 2; i++) begin
                    int     w;
                    bit     st, c, s;
                    longint ua, ub;
                    w  = (i == 0) ? 8 : 2;
                    st = (i == 0) ? start8 : start2;
                    c  = (i == 0) ? cin8 : cin2;
                    s  = (i == 0) ? sub8 : sub2;
                    ua = (i == 0) ? longint'(a8) : longint'(a2);
                    ub = (i == 0) ? longint'(b8) : longint'(b2);
                    if (m_act[i] && cyc == m_end[i]) begin
                        e_sum[i] = p_sum[i]; e_cout[i] = p_cout[i]; e_ovf[i] = p_ovf[i];
                    end
                    if ((!m_act[i] || cyc > m_end[i]) && st) begin
                        ref_op(w, ua, ub, c, s, p_sum[i], p_cout[i], p_ovf[i]);
                        m_end[i] = cyc + w;
                        m_act[i] = 1;
                    end
                    e_busy[i] = m_act[i] && cyc < m_end[i];
                    e_done[i] = m_act[i] && cyc == m_end[i];
                end
            end
        end
    end

    // Every-cycle compare of both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("busy8", busy8, e_busy[0]);
                chk("done8", done8, e_done[0]);
                chk("sum8", sum8, e_sum[0]);
                chk("cout8", cout8, e_cout[0]);
                chk("busy2", busy2, e_busy[1]);
                chk("done2", done2, e_done[1]);
                chk("sum2", sum2, e_sum[1]);
                chk("cout2", cout2, e_cout[1]);
`ifdef SERIAL_ADDER_OVF_EN
                chk("ovf8", ovf8, e_ovf[0]);
                chk("ovf2", ovf2, e_ovf[1]);
`endif
            end
        end
    end

    // WIDTH=2 random sweep, inputs churn every cycle including mid-run.
    initial begin
        forever begin
            @(negedge clk);
            if (run2) begin
                start2 = ($urandom_range(0, 3) != 0);
                a2     = 2'($urandom);
                b2     = 2'($urandom);
                cin2   = 1'($urandom);
                sub2   = 1'($urandom);
            end else begin
                start2 = 1'b0;
            end
        end
    end

    // One 8-bit operation; bb=1 starts in the current (done) cycle.
    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input bit tcin,
                       input bit tsub, input bit bb, input bit lit,
                       input logic [7:0] es, input bit ec, input bit eo);
        int nb = 0;
        if (!bb) @(negedge clk);
        a8 = ta; b8 = tb; cin8 = tcin; sub8 = tsub; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        for (int i = 0; i < 40 && !done8; i++) begin
            if (busy8) nb++;
            @(negedge clk);
        end
        chk("op8_done_seen", done8, 1);
        chk("op8_busy_cycles", nb, 8);
        if (lit) begin
            chk("op8_sum_lit", sum8, es);
            chk("op8_cout_lit", cout8, ec);
`ifdef SERIAL_ADDER_OVF_EN
            chk("op8_ovf_lit", ovf8, eo);
`else
            if (eo) n_checks += 0;
`endif
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint rs;
        bit     rc, ro;
        int     pulses;

        // Pin the reference model itself.
        ref_op(8, 'h5A, 'h3C, 0, 0, rs, rc, ro);
        chk("model_add", rs, 'h96);
        chk("model_add_c", rc, 0);
        ref_op(8, 'h20, 'h10, 1, 1, rs, rc, ro);
        chk("model_sub", rs, 'h0F);
        chk("model_sub_c", rc, 1);
        ref_op(8, 'h80, 'h01, 0, 1, rs, rc, ro);
        chk("model_sub_ovf", ro, 1);

        rst_n = 1'b0;
        @(posedge clk);
        #1 cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_sum", sum8, 0);
        chk("rst_cout", cout8, 0);
        #2 rst_n = 1'b1;
        run2 = 1'b1;

        op8(8'h5A, 8'h3C, 0, 0, 0, 1, 8'h96, 0, 0);
        op8(8'hFF, 8'h01, 1, 0, 0, 1, 8'h01, 1, 0);
        op8(8'h10, 8'h20, 0, 1, 0, 1, 8'hF0, 0, 0);
        op8(8'h20, 8'h10, 1, 1, 0, 1, 8'h0F, 1, 0);
        op8(8'h7F, 8'h01, 0, 0, 0, 1, 8'h80, 0, 1);
        op8(8'h80, 8'h01, 0, 1, 0, 1, 8'h7F, 1, 1);

        // start held high through RUN while operands change.
        @(negedge clk);
        a8 = 8'h33; b8 = 8'h44; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done8) begin
                pulses++;
                start8 = 1'b0;
                chk("held_sum", sum8, 'h77);
                chk("held_cout", cout8, 0);
            end else if (start8) begin
                a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
            end
        end
        chk("held_pulses", pulses, 1);

        // Back-to-back start at the edge ending the done cycle.
        op8(8'h5A, 8'h3C, 0, 0, 0, 1, 8'h96, 0, 0);
        op8(8'h10, 8'h20, 0, 1, 1, 1, 8'hF0, 0, 0);

        // Reset in the middle of a run.
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy8, 0);
        chk("midrst_done", done8, 0);
        chk("midrst_sum", sum8, 0);
        chk("midrst_cout", cout8, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) pulses++;
        end
        chk("midrst_no_done", pulses, 0);
        op8(8'hA5, 8'h5A, 1, 0, 0, 1, 8'h00, 1, 0);

        // Random 8-bit operations, some back to back.
        for (int k = 0; k < 60; k++) begin
            bit bb;
            bb = (k % 4 == 3);
            if (!bb) repeat ($urandom_range(0, 2)) @(negedge clk);
            op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), bb, 0, 8'h00, 0, 0);
        end

        run2 = 1'b0;
        repeat (6) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
